// File: rtl/led_game_pkg.sv
// Shared types for the LED game: capture FSM state encoding and the game switch width.
package led_game_pkg;

   localparam int unsigned GAME_WIDTH = 10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHECK   = 2'd1,
      HOLD    = 2'd2,
      RELEASE = 2'd3
   } state_t;

endpackage

// File: rtl/switch_debouncer.sv
// Bus-wide two-flop synchroniser followed by a single stability counter; deb only
// follows the synchronised pattern once it has stayed unchanged long enough.
module switch_debouncer
   import led_game_pkg::*;
#(
   parameter int unsigned WIDTH           = GAME_WIDTH,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] switch,
   output logic [WIDTH-1:0] deb
);

   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sw_s;
   logic [WIDTH-1:0] candidate;
   logic [CNT_W-1:0] cnt;

   // Any change of the synchronised bus restarts the count; the counter parks at max.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1     <= '0;
         sw_s      <= '0;
         candidate <= '0;
         cnt       <= '0;
         deb       <= '0;
      end else begin
         sync1 <= switch;
         sw_s  <= sync1;
         if (sw_s != candidate) begin
            candidate <= sw_s;
            cnt       <= '0;
         end else begin
            if (cnt != CNT_MAX) begin
               cnt <= cnt + CNT_W'(1);
            end
            if (cnt == STABLE_LAST) begin
               deb <= candidate;
            end
         end
      end
   end

endmodule

// File: rtl/switch_capture.sv
// Switch front end for the LED game: debounce, qualify one press, hold it for the game FSM.
// Build option SWITCH_CAPTURE_ODD_PARITY_EN relaxes qualification from one-hot to odd weight.
module switch_capture
   import led_game_pkg::*;
#(
   parameter int unsigned WIDTH           = GAME_WIDTH,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] switch,
   input  logic             ack,
   output logic [WIDTH-1:0] code,
   output logic             valid,
   output logic             err,
   output logic             busy
);

   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] snap;
   logic [WIDTH-1:0] snap_nx;
   logic [WIDTH-1:0] code_nx;
   logic             valid_nx;
   logic             err_nx;
   logic             busy_nx;
   logic             qualified_c;
   state_t           state;
   state_t           state_nx;

   switch_debouncer #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debouncer (
      .clock  (clock),
      .reset  (reset),
      .switch (switch),
      .deb    (deb)
   );

   // Qualification acts on the pattern frozen when CHECK was entered.
`ifdef SWITCH_CAPTURE_ODD_PARITY_EN
   assign qualified_c = (snap != '0) && (^snap);
`else
   assign qualified_c = (snap != '0) && ((snap & (snap - WIDTH'(1))) == '0);
`endif

   always_comb begin
      state_nx = state;
      snap_nx  = snap;
      code_nx  = code;
      valid_nx = valid;
      err_nx   = 1'b0;
      unique case (state)
         IDLE: begin
            if (deb != '0) begin
               state_nx = CHECK;
               snap_nx  = deb;
            end
         end
         CHECK: begin
            if (qualified_c) begin
               code_nx  = snap;
               valid_nx = 1'b1;
               state_nx = HOLD;
            end else begin
               err_nx   = 1'b1;
               state_nx = RELEASE;
            end
         end
         HOLD: begin
            if (ack) begin
               code_nx  = '0;
               valid_nx = 1'b0;
               state_nx = RELEASE;
            end
         end
         RELEASE: begin
            // No new capture until every switch has debounced low.
            if (deb == '0) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         snap  <= '0;
         code  <= '0;
         valid <= 1'b0;
         err   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         snap  <= snap_nx;
         code  <= code_nx;
         valid <= valid_nx;
         err   <= err_nx;
         busy  <= busy_nx;
      end
   end

endmodule

// File: tb/tb_switch_capture.sv
// Bench for switch_capture: directed scenarios plus random switch/ack/reset traffic,
// checked every cycle against a behavioural model of the debounce and capture rules.
module tb_switch_capture;

   localparam int unsigned W  = 10;
   localparam int unsigned D  = 4;
   localparam int unsigned CW = 3;

   localparam int P_WAIT = 0;
   localparam int P_CHK  = 1;
   localparam int P_HOLD = 2;
   localparam int P_REL  = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ack = 1'b0;
   logic [W-1:0] sw  = '0;
   logic [W-1:0] code;
   logic         valid;
   logic         err;
   logic         busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   switch_capture #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (CW)
   ) dut (
      .clock  (clk),
      .reset  (rst),
      .switch (sw),
      .ack    (ack),
      .code   (code),
      .valid  (valid),
      .err    (err),
      .busy   (busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit accept(input logic [W-1:0] v);
`ifdef SWITCH_CAPTURE_ODD_PARITY_EN
      return ($countones(v) % 2) == 1;
`else
      return $countones(v) == 1;
`endif
   endfunction

   // Behavioural model: a 2-deep delay line, then a value is believed once it has
   // been seen on D+1 consecutive edges; capture phases follow the handshake rules.
   logic [W-1:0] m_q1 = '0, m_q2 = '0, m_prev = '0, m_deb = '0, m_snap = '0, m_code = '0;
   logic         m_valid = 1'b0, m_err = 1'b0;
   int           m_run = 1;
   int           m_phase = P_WAIT;
   logic [W-1:0] s_now, old_deb;

   always begin
      @(posedge clk);
      if (rst) begin
         m_q1 = '0; m_q2 = '0; m_prev = '0; m_deb = '0; m_snap = '0; m_code = '0;
         m_valid = 1'b0; m_err = 1'b0; m_run = 1; m_phase = P_WAIT;
      end else begin
         s_now   = m_q2;
         old_deb = m_deb;
         m_q2    = m_q1;
         m_q1    = sw;
         if (s_now == m_prev) begin
            if (m_run < int'(D) + 2) m_run++;
         end else begin
            m_run  = 1;
            m_prev = s_now;
         end
         if (m_run == int'(D) + 1) m_deb = s_now;
         m_err = 1'b0;
         case (m_phase)
            P_WAIT: if (old_deb != '0) begin m_phase = P_CHK; m_snap = old_deb; end
            P_CHK: begin
               if (accept(m_snap)) begin
                  m_code = m_snap; m_valid = 1'b1; m_phase = P_HOLD;
               end else begin
                  m_err = 1'b1; m_phase = P_REL;
               end
            end
            P_HOLD: if (ack) begin m_code = '0; m_valid = 1'b0; m_phase = P_REL; end
            default: if (old_deb == '0) m_phase = P_WAIT;
         endcase
      end
      #1;
      chk("model_code", 32'(code), 32'(m_code));
      chk("model_valid", 32'(valid), 32'(m_valid));
      chk("model_err", 32'(err), 32'(m_err));
      chk("model_busy", 32'(busy), 32'(m_phase != P_WAIT));
   end

   // which: 0 = valid high, 1 = err high, 2 = busy low
   task automatic wait_flag(input string nm, input int which, input int limit);
      bit hit = 1'b0;
      for (int i = 0; i < limit && !hit; i++) begin
         @(posedge clk);
         #1;
         case (which)
            0:       hit = (valid === 1'b1);
            1:       hit = (err === 1'b1);
            default: hit = (busy === 1'b0);
         endcase
      end
      chk(nm, 32'(hit), 32'd1);
   endtask

   task automatic pulse_ack();
      @(negedge clk) ack = 1'b1;
      @(negedge clk) ack = 1'b0;
   endtask

   logic [W-1:0] pat;
   logic [W-1:0] one;

   initial begin
      one = W'(1);
      repeat (3) @(negedge clk);
      chk("reset_code", 32'(code), 32'd0);
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // Clean press: valid appears on the 9th edge counting the sampling edge as 0.
      sw = 10'h200;
      repeat (8) @(posedge clk);
      #1;
      chk("lat_not_yet", 32'(valid), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_valid", 32'(valid), 32'd1);
      chk("lat_code", 32'(code), 32'h200);
      chk("lat_err", 32'(err), 32'd0);

      // Switch change while held is ignored; ack releases on the next edge.
      @(negedge clk) sw = 10'h001;
      repeat (10) @(negedge clk);
      chk("hold_code", 32'(code), 32'h200);
      chk("hold_valid", 32'(valid), 32'd1);
      ack = 1'b1;
      @(posedge clk);
      #1;
      chk("ack_valid", 32'(valid), 32'd0);
      chk("ack_code", 32'(code), 32'd0);
      repeat (3) @(negedge clk);
      ack = 1'b0;
      repeat (15) @(negedge clk);
      chk("release_busy", 32'(busy), 32'd1);
      chk("release_valid", 32'(valid), 32'd0);
      sw = '0;
      wait_flag("release_idle", 2, 20);

      // Bounce faster than the stability window, then settle.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk) sw = (i % 2 == 0) ? 10'h008 : 10'h000;
         @(negedge clk);
         chk("bounce_valid", 32'(valid), 32'd0);
      end
      sw = 10'h008;
      wait_flag("settle_valid", 0, 20);
      chk("settle_code", 32'(code), 32'h008);
      pulse_ack();
      sw = '0;
      wait_flag("settle_idle", 2, 20);

      // Two switches up: rejected with a single-cycle err pulse.
      @(negedge clk) sw = 10'h003;
      wait_flag("multi_err", 1, 20);
      chk("multi_valid", 32'(valid), 32'd0);
      @(posedge clk);
      #1;
      chk("multi_err_pulse", 32'(err), 32'd0);
      chk("multi_busy", 32'(busy), 32'd1);
      repeat (10) @(negedge clk);
      chk("multi_wait", 32'(busy), 32'd1);
      sw = '0;
      wait_flag("multi_idle", 2, 20);

      // Three switches up: accepted only with odd-parity qualification.
      @(negedge clk) sw = 10'h007;
`ifdef SWITCH_CAPTURE_ODD_PARITY_EN
      wait_flag("odd_valid", 0, 20);
      chk("odd_code", 32'(code), 32'h007);
      pulse_ack();
`else
      wait_flag("odd_err", 1, 20);
      chk("odd_valid", 32'(valid), 32'd0);
`endif
      sw = '0;
      wait_flag("odd_idle", 2, 20);

      // All switches up is never a legal press.
      @(negedge clk) sw = '1;
      wait_flag("ones_err", 1, 20);
      sw = '0;
      wait_flag("ones_idle", 2, 20);

      // Asynchronous reset while holding, then normal capture afterwards.
      @(negedge clk) sw = 10'h040;
      wait_flag("rst_hold_valid", 0, 20);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_valid", 32'(valid), 32'd0);
      chk("rst_async_code", 32'(code), 32'd0);
      chk("rst_async_busy", 32'(busy), 32'd0);
      @(negedge clk) rst = 1'b0;
      wait_flag("rst_recap_valid", 0, 20);
      chk("rst_recap_code", 32'(code), 32'h040);
      pulse_ack();
      sw = '0;
      wait_flag("rst_idle", 2, 20);

      // Random traffic: patterns held for short random spans, random ack and rare reset.
      for (int seg = 0; seg < 250; seg++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: pat = '0;
            3, 4, 5: pat = one << $urandom_range(0, W - 1);
            6:       pat = '1;
            7:       pat = (one << $urandom_range(0, W - 1)) | (one << $urandom_range(0, W - 1));
            default: pat = W'($urandom);
         endcase
         for (int k = 0; k < int'($urandom_range(1, 14)); k++) begin
            @(negedge clk);
            sw  = pat;
            ack = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      ack = 1'b0;
      sw  = '0;
      repeat (4) @(negedge clk);
      ack = 1'b1;
      @(negedge clk) ack = 1'b0;
      wait_flag("final_idle", 2, 40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
